canal_lock_ctrl: RTL and testbench

Sequencing controller for the canal lock chamber. It consumes single-cycle arrive/depart request pulses from the switch edge-detect stage. It also arbitrates between those requests, drives the outer/inner gates and the fill/drain valves, and maintains a modelled chamber water level. The outer gate (river side) opens only at level 0; the inner gate (lake side) opens only at LEVEL_MAX.

---
 rtl/lock_pkg.sv | 26 ++
 rtl/canal_lock_ctrl_level_stepper.sv | 66 ++++++
 rtl/canal_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_canal_lock_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and default sizing for the canal lock controller.
package lock_pkg;

    localparam int DEF_LEVEL_W     = 4;
    localparam int DEF_LEVEL_MAX   = 15;
    localparam int DEF_STEP_CYCLES = 4;
    localparam int DEF_TIMEOUT     = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN      = 3'd1,
        ST_OUTER_OPEN = 3'd2,
        ST_FILL       = 3'd3,
        ST_INNER_OPEN = 3'd4
    } lock_state_t;

    typedef enum logic {
        DIR_ARRIVE = 1'b0,
        DIR_DEPART = 1'b1
    } lock_dir_t;

    function automatic logic is_gate_state(input lock_state_t st);
        return (st == ST_OUTER_OPEN) || (st == ST_INNER_OPEN);
    endfunction

endpackage

// File: rtl/canal_lock_ctrl_level_stepper.sv
// Step divider plus saturating up/down chamber level counter.
module level_stepper
    import lock_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               clear_step,
    output logic [LEVEL_W-1:0] level,
    output logic               at_min,
    output logic               at_max,
    output logic               step_wrap
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);

    logic [STEP_W-1:0]  step_r;
    logic [STEP_W-1:0]  step_next_s;
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_next_s;
    logic               run_s;
    logic               wrap_s;

    // Next step count and level; the wrap that moves the level also lands on the bound.
    always_comb begin
        run_s  = up | down;
        wrap_s = run_s && (step_r == STEP_LAST);
        if (clear_step || !run_s || wrap_s) begin
            step_next_s = {STEP_W{1'b0}};
        end else begin
            step_next_s = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
        end
        if (wrap_s && up && (level_r != LVL_MAX)) begin
            level_next_s = level_r + LVL_ONE;
        end else if (wrap_s && down && (level_r != {LEVEL_W{1'b0}})) begin
            level_next_s = level_r - LVL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    // Step and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r  <= {STEP_W{1'b0}};
            level_r <= {LEVEL_W{1'b0}};
        end else begin
            step_r  <= step_next_s;
            level_r <= level_next_s;
        end
    end

    assign level     = level_r;
    assign at_min    = (level_r == {LEVEL_W{1'b0}});
    assign at_max    = (level_r == LVL_MAX);
    assign step_wrap = wrap_s;

endmodule

// File: rtl/canal_lock_ctrl.sv
// Canal lock sequencer: request arbitration, gate/valve control, level model.
// Optional gate-open watchdog enabled by defining LOCK_TIMEOUT_EN.
module canal_lock_ctrl
    import lock_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arrive_req,
    input  logic               depart_req,
    input  logic               boat_pass,
    output logic               outer_gate_open,
    output logic               inner_gate_open,
    output logic               fill_valve,
    output logic               drain_valve,
    output logic [LEVEL_W-1:0] water_level,
    output logic               busy,
    output logic               arrive_pending,
    output logic               depart_pending,
    output logic               fault
);

    localparam logic [LEVEL_W-1:0] LVL_ONE    = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LVL_MAX_M1 = LEVEL_W'(LEVEL_MAX - 1);

    lock_state_t        state_r, state_next_s;
    lock_dir_t          dir_r, dir_next_s;
    lock_dir_t          last_r, last_next_s;
    logic               phase_r, phase_next_s;
    logic               arr_pend_r, dep_pend_r;
    logic               eff_arr_s, eff_dep_s;
    logic               grant_arr_s, grant_dep_s;
    logic               abort_s;
    logic [LEVEL_W-1:0] level_s;
    logic               at_min_s, at_max_s, step_wrap_s;
    logic               outer_r, inner_r, fill_r, drain_r, busy_r;

    level_stepper #(
        .LEVEL_W     (LEVEL_W),
        .LEVEL_MAX   (LEVEL_MAX),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_stepper (
        .clk        (clk),
        .rst        (rst),
        .up         (state_r == ST_FILL),
        .down       (state_r == ST_DRAIN),
        .clear_step (state_next_s != state_r),
        .level      (level_s),
        .at_min     (at_min_s),
        .at_max     (at_max_s),
        .step_wrap  (step_wrap_s)
    );

`ifdef LOCK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_r;
    logic            fault_r;

    // Watchdog counts consecutive gate-open cycles; fault is the registered abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_r    <= {WD_W{1'b0}};
            fault_r <= 1'b0;
        end else begin
            wd_r    <= (is_gate_state(state_r) && is_gate_state(state_next_s)) ?
                       wd_r + {{(WD_W-1){1'b0}}, 1'b1} : {WD_W{1'b0}};
            fault_r <= abort_s;
        end
    end
    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    // Arbitration and next-state decode; a same-edge request in IDLE is granted directly.
    always_comb begin
        eff_arr_s    = arr_pend_r | arrive_req;
        eff_dep_s    = dep_pend_r | depart_req;
        state_next_s = state_r;
        dir_next_s   = dir_r;
        last_next_s  = last_r;
        phase_next_s = phase_r;
        grant_arr_s  = 1'b0;
        grant_dep_s  = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (eff_arr_s && (!eff_dep_s || (last_r == DIR_DEPART))) begin
                    grant_arr_s  = 1'b1;
                    dir_next_s   = DIR_ARRIVE;
                    last_next_s  = DIR_ARRIVE;
                    phase_next_s = 1'b0;
                    state_next_s = at_min_s ? ST_OUTER_OPEN : ST_DRAIN;
                end else if (eff_dep_s) begin
                    grant_dep_s  = 1'b1;
                    dir_next_s   = DIR_DEPART;
                    last_next_s  = DIR_DEPART;
                    phase_next_s = 1'b0;
                    state_next_s = at_max_s ? ST_INNER_OPEN : ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (at_min_s || (step_wrap_s && (level_s == LVL_ONE))) begin
                    state_next_s = ST_OUTER_OPEN;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_FILL: begin
                if (at_max_s || (step_wrap_s && (level_s == LVL_MAX_M1))) begin
                    state_next_s = ST_INNER_OPEN;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_OUTER_OPEN: begin
                if (boat_pass && (phase_r == 1'b0)) begin
                    phase_next_s = 1'b1;
                    state_next_s = ST_FILL;
                end else if (boat_pass) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUTER_OPEN;
                end
            end
            ST_INNER_OPEN: begin
                if (boat_pass && (phase_r == 1'b0)) begin
                    phase_next_s = 1'b1;
                    state_next_s = ST_DRAIN;
                end else if (boat_pass) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_INNER_OPEN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
`ifdef LOCK_TIMEOUT_EN
        if (is_gate_state(state_r) && !boat_pass && (wd_r == WD_LAST)) begin
            abort_s      = 1'b1;
            state_next_s = ST_IDLE;
        end else begin
            abort_s = 1'b0;
        end
`endif
    end

    // State, arbitration bookkeeping and Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dir_r      <= DIR_ARRIVE;
            last_r     <= DIR_DEPART;
            phase_r    <= 1'b0;
            arr_pend_r <= 1'b0;
            dep_pend_r <= 1'b0;
            outer_r    <= 1'b0;
            inner_r    <= 1'b0;
            fill_r     <= 1'b0;
            drain_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            dir_r      <= dir_next_s;
            last_r     <= last_next_s;
            phase_r    <= phase_next_s;
            arr_pend_r <= eff_arr_s & ~grant_arr_s;
            dep_pend_r <= eff_dep_s & ~grant_dep_s;
            outer_r    <= (state_next_s == ST_OUTER_OPEN);
            inner_r    <= (state_next_s == ST_INNER_OPEN);
            fill_r     <= (state_next_s == ST_FILL);
            drain_r    <= (state_next_s == ST_DRAIN);
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    assign outer_gate_open = outer_r;
    assign inner_gate_open = inner_r;
    assign fill_valve      = fill_r;
    assign drain_valve     = drain_r;
    assign busy            = busy_r;
    assign arrive_pending  = arr_pend_r;
    assign depart_pending  = dep_pend_r;
    assign water_level     = level_s;

endmodule

// File: tb/tb_canal_lock_ctrl.sv
// Scoreboard bench for canal_lock_ctrl with LEVEL_MAX=3, STEP_CYCLES=2, TIMEOUT=8.
module tb_canal_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arrive_req = 1'b0;
    logic       depart_req = 1'b0;
    logic       boat_pass = 1'b0;
    logic       outer_gate_open, inner_gate_open, fill_valve, drain_valve;
    logic [3:0] water_level;
    logic       busy, arrive_pending, depart_pending, fault;

    int tests_run = 0;
    int tests_failed = 0;

    // Output vector: {outer, inner, fill, drain, busy, arrive_pend, depart_pend, fault}
    localparam logic [7:0] IDL = 8'b0000_0000;
    localparam logic [7:0] OUT = 8'b1000_1000;
    localparam logic [7:0] INN = 8'b0100_1000;
    localparam logic [7:0] FIL = 8'b0010_1000;
    localparam logic [7:0] DRN = 8'b0001_1000;
    localparam logic [7:0] AP  = 8'b0000_0100;
    localparam logic [7:0] DP  = 8'b0000_0010;
    localparam logic [7:0] FLT = 8'b0000_0001;

    typedef struct {
        logic       a;
        logic       d;
        logic       p;
        logic [7:0] outs;
        logic [3:0] lvl;
    } sb_t;

    sb_t sb_q[$];

    canal_lock_ctrl #(
        .LEVEL_W     (4),
        .LEVEL_MAX   (3),
        .STEP_CYCLES (2),
        .TIMEOUT     (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .arrive_req      (arrive_req),
        .depart_req      (depart_req),
        .boat_pass       (boat_pass),
        .outer_gate_open (outer_gate_open),
        .inner_gate_open (inner_gate_open),
        .fill_valve      (fill_valve),
        .drain_valve     (drain_valve),
        .water_level     (water_level),
        .busy            (busy),
        .arrive_pending  (arrive_pending),
        .depart_pending  (depart_pending),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {outer_gate_open, inner_gate_open, fill_valve, drain_valve,
                busy, arrive_pending, depart_pending, fault, water_level};
    endfunction

    task automatic push(input logic a, input logic d, input logic p,
                        input logic [7:0] o, input logic [3:0] l);
        sb_t e;
        e.a = a; e.d = d; e.p = p; e.outs = o; e.lvl = l;
        sb_q.push_back(e);
    endtask

    // Drive one entry's inputs for one edge and return what the DUT shows afterwards.
    task automatic tick(input sb_t e, output logic [11:0] got);
        arrive_req = e.a;
        depart_req = e.d;
        boat_pass  = e.p;
        @(posedge clk);
        #1;
        arrive_req = 1'b0;
        depart_req = 1'b0;
        boat_pass  = 1'b0;
        got = observed();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        arrive_req = 1'b0; depart_req = 1'b0; boat_pass = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        @(posedge clk);
        #1;
        got = observed();
        tests_run++;
        if (got !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_held: got %b required %b", got, 12'h000);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        got = observed();
        tests_run++;
        if (got !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_release: got %b required %b", got, 12'h000);
        end
    endtask

    task automatic test_arrive();
        sb_t e; logic [11:0] got; int cyc = 0;
        push(1'b1, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b1, FIL, 4'd0);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd0);
        push(1'b0, 1'b0, 1'b1, FIL, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd2);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd2);
        push(1'b0, 1'b0, 1'b0, INN, 4'd3);
        push(1'b0, 1'b0, 1'b0, INN, 4'd3);
        push(1'b0, 1'b0, 1'b1, IDL, 4'd3);
        push(1'b0, 1'b0, 1'b1, IDL, 4'd3);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tick(e, got);
            tests_run++;
            if (got !== {e.outs, e.lvl}) begin
                tests_failed++;
                $display("FAIL arrive cycle %0d: got %b required %b", cyc, got, {e.outs, e.lvl});
            end
            cyc++;
        end
    endtask

    task automatic test_depart();
        sb_t e; logic [11:0] got; int cyc = 0;
        push(1'b0, 1'b1, 1'b0, INN, 4'd3);
        push(1'b0, 1'b0, 1'b0, INN, 4'd3);
        push(1'b0, 1'b0, 1'b1, DRN, 4'd3);
        push(1'b0, 1'b0, 1'b0, DRN, 4'd3);
        push(1'b0, 1'b0, 1'b0, DRN, 4'd2);
        push(1'b0, 1'b0, 1'b0, DRN, 4'd2);
        push(1'b0, 1'b0, 1'b0, DRN, 4'd1);
        push(1'b0, 1'b0, 1'b0, DRN, 4'd1);
        push(1'b0, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b1, IDL, 4'd0);
        push(1'b0, 1'b0, 1'b0, IDL, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tick(e, got);
            tests_run++;
            if (got !== {e.outs, e.lvl}) begin
                tests_failed++;
                $display("FAIL depart cycle %0d: got %b required %b", cyc, got, {e.outs, e.lvl});
            end
            cyc++;
        end
    endtask

    // Tie at reset goes to ARRIVE; a second tie after that must go to DEPART.
    task automatic test_tie();
        sb_t e; logic [11:0] got; int cyc = 0;
        apply_reset();
        push(1'b1, 1'b1, 1'b0, OUT | DP, 4'd0);
        push(1'b0, 1'b0, 1'b1, FIL | DP, 4'd0);
        push(1'b1, 1'b0, 1'b0, FIL | DP | AP, 4'd0);
        push(1'b0, 1'b0, 1'b0, FIL | DP | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL | DP | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL | DP | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, FIL | DP | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, INN | DP | AP, 4'd3);
        push(1'b0, 1'b0, 1'b1, DP | AP, 4'd3);
        push(1'b0, 1'b0, 1'b0, INN | AP, 4'd3);
        push(1'b0, 1'b0, 1'b1, DRN | AP, 4'd3);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd3);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, OUT | AP, 4'd0);
        push(1'b0, 1'b0, 1'b1, AP, 4'd0);
        push(1'b0, 1'b0, 1'b0, OUT, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tick(e, got);
            tests_run++;
            if (got !== {e.outs, e.lvl}) begin
                tests_failed++;
                $display("FAIL tie cycle %0d: got %b required %b", cyc, got, {e.outs, e.lvl});
            end
            cyc++;
        end
    endtask

    task automatic test_absorb();
        sb_t e; logic [11:0] got; int cyc = 0;
        apply_reset();
        push(1'b0, 1'b1, 1'b0, FIL, 4'd0);
        push(1'b1, 1'b0, 1'b0, FIL | AP, 4'd0);
        push(1'b1, 1'b0, 1'b0, FIL | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL | AP, 4'd1);
        push(1'b1, 1'b0, 1'b0, FIL | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, FIL | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, INN | AP, 4'd3);
        push(1'b0, 1'b0, 1'b1, DRN | AP, 4'd3);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd3);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd2);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, DRN | AP, 4'd1);
        push(1'b0, 1'b0, 1'b0, OUT | AP, 4'd0);
        push(1'b0, 1'b0, 1'b1, AP, 4'd0);
        push(1'b0, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b1, FIL, 4'd0);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd0);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd2);
        push(1'b0, 1'b0, 1'b0, FIL, 4'd2);
        push(1'b0, 1'b0, 1'b0, INN, 4'd3);
        push(1'b0, 1'b0, 1'b1, IDL, 4'd3);
        push(1'b0, 1'b0, 1'b0, IDL, 4'd3);
        push(1'b0, 1'b0, 1'b0, IDL, 4'd3);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tick(e, got);
            tests_run++;
            if (got !== {e.outs, e.lvl}) begin
                tests_failed++;
                $display("FAIL absorb cycle %0d: got %b required %b", cyc, got, {e.outs, e.lvl});
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_fill();
        sb_t e; logic [11:0] got; int cyc = 0;
        apply_reset();
        push(1'b1, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b1, FIL, 4'd0);
        push(1'b0, 1'b1, 1'b0, FIL | DP, 4'd0);
        push(1'b0, 1'b0, 1'b0, FIL | DP, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL | DP, 4'd1);
        push(1'b0, 1'b0, 1'b0, FIL | DP, 4'd2);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tick(e, got);
            tests_run++;
            if (got !== {e.outs, e.lvl}) begin
                tests_failed++;
                $display("FAIL midfill cycle %0d: got %b required %b", cyc, got, {e.outs, e.lvl});
            end
            cyc++;
        end
        #2;
        rst = 1'b1;
        #1;
        got = observed();
        tests_run++;
        if (got !== 12'h000) begin
            tests_failed++;
            $display("FAIL midfill_async_reset: got %b required %b", got, 12'h000);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(1'b0, 1'b0, 1'b0, IDL, 4'd0);
        e = sb_q.pop_front();
        tick(e, got);
        tests_run++;
        if (got !== {e.outs, e.lvl}) begin
            tests_failed++;
            $display("FAIL midfill_after_reset: got %b required %b", got, {e.outs, e.lvl});
        end
    endtask

    task automatic test_timeout();
        sb_t e; logic [11:0] got; int cyc = 0;
        apply_reset();
        push(1'b1, 1'b0, 1'b0, OUT, 4'd0);
`ifdef LOCK_TIMEOUT_EN
        for (int i = 0; i < 7; i++) push(1'b0, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b0, FLT, 4'd0);
        push(1'b0, 1'b0, 1'b0, IDL, 4'd0);
        push(1'b0, 1'b0, 1'b1, IDL, 4'd0);
`else
        for (int i = 0; i < 11; i++) push(1'b0, 1'b0, 1'b0, OUT, 4'd0);
        push(1'b0, 1'b0, 1'b1, FIL, 4'd0);
`endif
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tick(e, got);
            tests_run++;
            if (got !== {e.outs, e.lvl}) begin
                tests_failed++;
                $display("FAIL timeout cycle %0d: got %b required %b", cyc, got, {e.outs, e.lvl});
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_arrive();
        test_depart();
        test_tie();
        test_absorb();
        test_reset_mid_fill();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
